// File: rtl/activation_pipe_if.sv
// Stream and control bundle for activation_pipe.
// master: the side that programs transfers, sources input beats and sinks results.
// slave : the activation unit itself.
`timescale 1ns/1ps
interface activation_pipe_if #(
  parameter int NUM_LANES = 4,
  parameter int DWIDTH    = 8,
  parameter int CNT_WIDTH = 16
);
  logic                          start;
  logic [1:0]                    mode;
  logic [CNT_WIDTH-1:0]          num_beats;
  logic                          in_valid;
  logic                          in_ready;
  logic [NUM_LANES*DWIDTH-1:0]   in_data;
  logic [NUM_LANES-1:0]          in_mask;
  logic                          out_valid;
  logic                          out_ready;
  logic [NUM_LANES*DWIDTH-1:0]   out_data;
  logic [NUM_LANES-1:0]          out_mask;
  logic                          busy;
  logic                          done;

  modport master (
    output start, mode, num_beats, in_valid, in_data, in_mask, out_ready,
    input  in_ready, out_valid, out_data, out_mask, busy, done
  );

  modport slave (
    input  start, mode, num_beats, in_valid, in_data, in_mask, out_ready,
    output in_ready, out_valid, out_data, out_mask, busy, done
  );
endinterface

// File: rtl/activation_pipe.sv
// Pipelined per-lane activation unit: bypass / ReLU / leaky ReLU / PWL tanh,
// with valid/ready backpressure, per-lane mask and a programmed beat count.
// Optional feature macro: ACTIVATION_TANH_EN builds the tanh datapath; when it
// is undefined, mode 11 falls back to ReLU.
// Pipeline: input register -> lane decode register -> result register, all
// three advancing together whenever the output register can move.
`timescale 1ns/1ps
module activation_pipe #(
  parameter int NUM_LANES = 4,
  parameter int DWIDTH    = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  activation_pipe_if.slave  bus
);
  localparam int LW = NUM_LANES * DWIDTH;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic                   w_done;
  logic                   w_busy;

  logic [1:0]             r_mode;
  logic [CNT_WIDTH-1:0]   r_num_beats;
  logic [CNT_WIDTH-1:0]   r_acc_cnt;
  logic [CNT_WIDTH-1:0]   r_emit_cnt;

  logic                   w_adv;
  logic                   w_start_ok;
  logic                   w_in_ready;
  logic                   w_accept;
  logic                   w_emit;

  // input register stage
  logic                   r_s0_valid;
  logic [LW-1:0]          r_s0_data;
  logic [NUM_LANES-1:0]   r_s0_mask;

  // lane decode stage
  logic                   r_s1_valid;
  logic [LW-1:0]          r_s1_raw;
  logic [NUM_LANES-1:0]   r_s1_sign;
  logic [NUM_LANES-1:0]   r_s1_mask;
  logic [NUM_LANES-1:0]   w_sign;
`ifdef ACTIVATION_TANH_EN
  logic [LW-1:0]          r_s1_mag;
  logic [2*NUM_LANES-1:0] r_s1_seg;
  logic [LW-1:0]          w_mag;
  logic [2*NUM_LANES-1:0] w_seg;
`endif

  // result stage
  logic [LW-1:0]          w_result;
  logic                   r_out_valid;
  logic [LW-1:0]          r_out_data;
  logic [NUM_LANES-1:0]   r_out_mask;

  // Whole pipe moves only when the output register is empty or being drained.
  assign w_adv      = !r_out_valid || bus.out_ready;
  assign w_start_ok = bus.start && (r_state == ST_IDLE);
  assign w_in_ready = (r_state == ST_RUN) && (r_acc_cnt < r_num_beats) && w_adv;
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_emit     = r_out_valid && bus.out_ready;

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_mask  = r_out_mask;
  assign bus.busy      = w_busy;
  assign bus.done      = w_done;

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // FSM next state; done is asserted on the DRAIN->IDLE transition cycle
  always_comb begin
    w_state_next = r_state;
    w_done       = 1'b0;
    w_busy       = (r_state != ST_IDLE);
    case (r_state)
      ST_IDLE: begin
        if (bus.start) w_state_next = (bus.num_beats == '0) ? ST_DRAIN : ST_RUN;
      end
      ST_RUN: begin
        if (r_acc_cnt == r_num_beats) w_state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (r_emit_cnt == r_num_beats) begin
          w_state_next = ST_IDLE;
          w_done       = 1'b1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Transfer setup latch and independent accept/emit counters
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mode      <= 2'b00;
      r_num_beats <= '0;
      r_acc_cnt   <= '0;
      r_emit_cnt  <= '0;
    end else if (w_start_ok) begin
      r_mode      <= bus.mode;
      r_num_beats <= bus.num_beats;
      r_acc_cnt   <= '0;
      r_emit_cnt  <= '0;
    end else begin
      if (w_accept) r_acc_cnt  <= r_acc_cnt + CNT_WIDTH'(1);
      if (w_emit)   r_emit_cnt <= r_emit_cnt + CNT_WIDTH'(1);
    end
  end

`ifdef ACTIVATION_TANH_EN
  localparam int MAX_VAL = 1 << (DWIDTH - 1);
  localparam logic [DWIDTH-1:0]        L_QUARTER  = DWIDTH'(MAX_VAL / 4);
  localparam logic [DWIDTH-1:0]        L_THREE_Q  = DWIDTH'((3 * MAX_VAL) / 4);
  localparam logic signed [DWIDTH+1:0] L_3_8      = (DWIDTH+2)'((3 * MAX_VAL) / 8);
  localparam logic signed [DWIDTH+1:0] L_SAT      = (DWIDTH+2)'(MAX_VAL - 1);
  localparam logic signed [DWIDTH-1:0] L_SAT_D    = DWIDTH'(MAX_VAL - 1);
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane_decode
      assign w_sign[gi] = r_s0_data[gi*DWIDTH + DWIDTH - 1];
`ifdef ACTIVATION_TANH_EN
      logic [DWIDTH-1:0] w_x;
      logic [DWIDTH-1:0] w_m;
      assign w_x = r_s0_data[gi*DWIDTH +: DWIDTH];
      // |x| fits DWIDTH unsigned bits, including |-MAX| = MAX
      assign w_m = w_x[DWIDTH-1] ? (~w_x + DWIDTH'(1)) : w_x;
      assign w_mag[gi*DWIDTH +: DWIDTH] = w_m;
      assign w_seg[2*gi +: 2] = (w_m < L_QUARTER) ? 2'd0 :
                                ((w_m < L_THREE_Q) ? 2'd1 : 2'd2);
`endif
    end

    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane_act
      logic signed [DWIDTH-1:0] w_raw;
      logic signed [DWIDTH-1:0] w_res;
      logic                     w_neg;
      logic                     w_msk;
      assign w_raw = r_s1_raw[gi*DWIDTH +: DWIDTH];
      assign w_neg = r_s1_sign[gi];
      assign w_msk = r_s1_mask[gi];

`ifdef ACTIVATION_TANH_EN
      logic [DWIDTH-1:0]        w_m;
      logic [1:0]               w_sg;
      logic signed [DWIDTH+1:0] w_t;
      logic signed [DWIDTH+1:0] w_ty;
      logic signed [DWIDTH-1:0] w_tanh;
      assign w_m  = r_s1_mag[gi*DWIDTH +: DWIDTH];
      assign w_sg = r_s1_seg[2*gi +: 2];

      // Three-segment tanh on |x| with two guard bits, sign restored, then clamped
      always_comb begin
        w_t    = '0;
        w_ty   = '0;
        w_tanh = '0;
        case (w_sg)
          2'd0:    w_t = signed'({1'b0, w_m, 1'b0});
          2'd1:    w_t = signed'({2'b00, w_m} >> 1) + L_3_8;
          default: w_t = L_SAT;
        endcase
        w_ty = w_neg ? -w_t : w_t;
        if (w_ty > L_SAT)       w_tanh = L_SAT_D;
        else if (w_ty < -L_SAT) w_tanh = -L_SAT_D;
        else                    w_tanh = w_ty[DWIDTH-1:0];
      end
`endif

      // Mode select; a masked lane always produces zero
      always_comb begin
        w_res = '0;
        case (r_mode)
          2'b00:   w_res = w_raw;
          2'b01:   w_res = w_neg ? '0 : w_raw;
          2'b10:   w_res = w_neg ? (w_raw >>> 3) : w_raw;
          default: begin
`ifdef ACTIVATION_TANH_EN
            w_res = w_tanh;
`else
            w_res = w_neg ? '0 : w_raw;
`endif
          end
        endcase
        if (!w_msk) w_res = '0;
      end

      assign w_result[gi*DWIDTH +: DWIDTH] = w_res;
    end
  endgenerate

  // Pipeline registers: all stages hold together under backpressure
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s0_valid  <= 1'b0;
      r_s0_data   <= '0;
      r_s0_mask   <= '0;
      r_s1_valid  <= 1'b0;
      r_s1_raw    <= '0;
      r_s1_sign   <= '0;
      r_s1_mask   <= '0;
`ifdef ACTIVATION_TANH_EN
      r_s1_mag    <= '0;
      r_s1_seg    <= '0;
`endif
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_mask  <= '0;
    end else if (w_adv) begin
      r_s0_valid  <= w_accept;
      r_s0_data   <= bus.in_data;
      r_s0_mask   <= bus.in_mask;
      r_s1_valid  <= r_s0_valid;
      r_s1_raw    <= r_s0_data;
      r_s1_sign   <= w_sign;
      r_s1_mask   <= r_s0_mask;
`ifdef ACTIVATION_TANH_EN
      r_s1_mag    <= w_mag;
      r_s1_seg    <= w_seg;
`endif
      r_out_valid <= r_s1_valid;
      r_out_data  <= w_result;
      r_out_mask  <= r_s1_mask;
    end
  end
endmodule
